tea_apb_sched: RTL
==================

// Module: tea_apb_sched
// PURPOSE
//  APB-programmed controller that sequences 32-bit words through one tinyenc and one tinydec core.
//  It holds the shared config: key, delta and round count, plus enc/dec mode.
//  It buffers input words in a TX FIFO and issues them one at a time to the core selected by mode.
//  It waits for that core's valid, then pushes the result into an RX FIFO for software to read.
// PARAMETERS
//  DEPTH  4     TX/RX FIFO depth in words; power of 2, >=2
//  TMO    255   max cycles in WAIT before timeout abort; 8-bit compare
// PORTS
//  clk        in   1   single clock; APB and cores share it
//  rstb       in   1   asynchronous active-low reset
//  psel       in   1   APB select
//  penable    in   1   APB enable (access phase)
//  pwrite     in   1   APB write
//  paddr      in   5   APB byte address; [1:0] ignored
//  pwdata     in   32  APB write data
//  prdata     out  32  APB read data
//  pready     out  1   tied 1 (zero wait-state)
//  pslverr    out  1   error response, valid in access phase
//  irq        out  1   (~rx_empty & CTRL.ie) | STATUS.err
//  core_delta out  16  shadow delta to both cores
//  core_round out  3   shadow round to both cores
//  core_key   out  64  shadow key to both cores
//  core_wdata out  32  word under processing
//  enc_write  out  1   1-cycle start strobe to tinyenc
//  dec_write  out  1   1-cycle start strobe to tinydec
//  enc_valid  in   1   tinyenc result ready (level)
//  enc_rdata  in   32  tinyenc result
//  dec_valid  in   1   tinydec result ready (level)
//  dec_rdata  in   32  tinydec result
// BEHAVIOUR
//  Reset: all regs, FIFOs, shadows and outputs 0; prdata=0, pslverr=0, irq=0; FSM=IDLE.
//  Registers, APB write takes effect at the access-phase edge:
//   0x00 CTRL:   [0] en; [1] mode (0=enc, 1=dec); [2] clr (self-clearing); [3] ie
//   0x04 CFG:    [2:0] round; [31:16] delta
//   0x08 KEYLO:  key[31:0]
//   0x0C KEYHI:  key[63:32]
//   0x10 TXDATA: write pushes TX FIFO
//   0x14 RXDATA: read pops RX FIFO; data is the head word
//   0x18 STATUS: [0] tx_full; [1] tx_empty; [2] rx_full; [3] rx_empty; [4] busy; [5] err (W1C);
//                [11:8] tx_cnt; [15:12] rx_cnt
//  pslverr=1 when: TXDATA write while tx_full (word dropped); RXDATA read while rx_empty (prdata=0,
//   no pop); unmapped address (no effect). No other access errors.
//  FSM:
//   IDLE:  go to ISSUE when en & ~tx_empty & (rx_cnt + 0 < DEPTH); busy=0 only in IDLE.
//   ISSUE: one cycle. Pop TX into core_wdata; latch CFG/KEY/mode into shadows; pulse the mode's write
//          strobe; clear timer. Next state WAIT.
//   WAIT:  sample the selected valid, registered with previous value. On rising edge go to STORE.
//          Else timer++; when timer==TMO set err and go to IDLE, word dropped.
//   STORE: push selected rdata into RX; go to IDLE.
//   A slot is guaranteed because ISSUE requires ~rx_full and RX pops only free space.
//  Latency: TX push -> ISSUE >= 1 cycle; STORE -> RX visible next cycle.
//  Config/mode writes during busy update the registers only. Shadows and core_* outputs stay
//   constant until the next ISSUE.
//  clr=1: flush both FIFOs (counts 0) and force IDLE from any state. An in-flight result is
//   discarded. Has priority over a same-cycle push or pop. err is unaffected.
//  en=0 mid-operation: the current word completes to STORE; no new ISSUE.
//  Simultaneous TXDATA push and ISSUE pop: both happen, tx_cnt unchanged. Same for RX pop and STORE.
//  FIFO pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
//  Async reset mid-WAIT: immediate IDLE; strobes drop asynchronously.
// TESTING
//  1. Program KEY=0x0123456789ABCDEF, delta=0x9E37, round=3, mode=enc, en=1; push 0x41424344
//     -> exactly one enc_write pulse, dec_write=0, RX holds enc_rdata.
//  2. Push 4 words with en=0 (DEPTH=4) -> tx_full=1; 5th push -> pslverr=1, tx_cnt=4.
//     Set en -> 4 results in order.
//  3. Encrypt 8 random words, read them, set mode=dec, push ciphers back -> RX words equal originals.
//  4. Hold enc_valid=0 after ISSUE -> err=1 after TMO cycles, irq=1, FSM IDLE.
//     W1C err -> irq=0, next word processes.
//  5. Write CFG.round=5 during WAIT -> core_round unchanged until next ISSUE. clr in WAIT -> counts 0,
//     late valid ignored, no RX push.
//  6. Read RXDATA while empty -> pslverr=1, prdata=0. Assert rstb=0 mid-WAIT -> all outputs 0
//     immediately.

Source files
------------

// File: rtl/tea_apb_sched_if.sv
// APB slave bus bundle for tea_apb_sched.
interface tea_apb_sched_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/tea_apb_sched.sv
// APB-programmed scheduler: buffers words in a TX FIFO, issues them one at a time to the
// tinyenc/tinydec core selected by mode, and collects results into an RX FIFO.
module tea_apb_sched #(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  TMO   = 8'd255
) (
  input  logic           clk,
  input  logic           rstb,
  tea_apb_sched_if.slave apb,
  output logic           irq,
  output logic [15:0]    core_delta,
  output logic [2:0]     core_round,
  output logic [63:0]    core_key,
  output logic [31:0]    core_wdata,
  output logic           enc_write,
  output logic           dec_write,
  input  logic           enc_valid,
  input  logic [31:0]    enc_rdata,
  input  logic           dec_valid,
  input  logic [31:0]    dec_rdata
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_e;
  typedef enum logic [2:0] {
    R_CTRL = 3'd0, R_CFG, R_KEYLO, R_KEYHI, R_TXDATA, R_RXDATA, R_STATUS, R_NONE
  } reg_e;

  state_e        state_q, state_d;
  reg_e          ridx;
  logic          ctrl_en, ctrl_mode, ctrl_ie, err;
  logic [2:0]    cfg_round;
  logic [15:0]   cfg_delta;
  logic [63:0]   key;
  logic          sh_mode;
  logic [7:0]    timer;
  logic          vld_q;
  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          wr_acc, rd_acc, clr, issue;
  logic          tx_full, tx_empty, rx_full, rx_empty, busy;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          vld_sel, vld_rise, timeout;
  logic [3:0]    tx_cnt4, rx_cnt4;
  logic [31:0]   prdata_c;
  logic          unused_addr;

  assign unused_addr = ^apb.paddr[1:0];

  assign wr_acc = apb.psel & apb.penable & apb.pwrite;
  assign rd_acc = apb.psel & apb.penable & ~apb.pwrite;
  assign ridx   = reg_e'(apb.paddr[4:2]);

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign busy     = (state_q != S_IDLE);
  assign tx_cnt4  = 4'(tx_cnt);
  assign rx_cnt4  = 4'(rx_cnt);

  assign clr     = wr_acc & (ridx == R_CTRL) & apb.pwdata[2];
  assign issue   = (state_q == S_ISSUE) & ~clr;
  assign tx_push = wr_acc & (ridx == R_TXDATA) & ~tx_full;
  assign tx_pop  = (state_q == S_ISSUE);
  assign rx_push = (state_q == S_STORE);
  assign rx_pop  = rd_acc & (ridx == R_RXDATA) & ~rx_empty;

  // In ISSUE the shadow mode is not yet loaded, so edge history tracks the mode about to run.
  assign vld_sel  = ((state_q == S_ISSUE) ? ctrl_mode : sh_mode) ? dec_valid : enc_valid;
  assign vld_rise = vld_sel & ~vld_q;
  assign timeout  = (state_q == S_WAIT) & ~vld_rise & (timer == TMO);

  assign irq = (~rx_empty & ctrl_ie) | err;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ctrl_en && !tx_empty && !rx_full) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (vld_rise)           state_d = S_STORE;
        else if (timer == TMO)  state_d = S_IDLE;
      end
      S_STORE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 1'b0;
      ctrl_ie   <= 1'b0;
      cfg_round <= '0;
      cfg_delta <= '0;
      key       <= '0;
      err       <= 1'b0;
    end else begin
      if (wr_acc) begin
        case (ridx)
          R_CTRL: begin
            ctrl_en   <= apb.pwdata[0];
            ctrl_mode <= apb.pwdata[1];
            ctrl_ie   <= apb.pwdata[3];
          end
          R_CFG: begin
            cfg_round <= apb.pwdata[2:0];
            cfg_delta <= apb.pwdata[31:16];
          end
          R_KEYLO: key[31:0]  <= apb.pwdata;
          R_KEYHI: key[63:32] <= apb.pwdata;
          default: ;
        endcase
      end
      if (timeout)
        err <= 1'b1;
      else if (wr_acc && ridx == R_STATUS && apb.pwdata[5])
        err <= 1'b0;
    end
  end

  // Strobes are registered with the shadows so a core sees a consistent word/config with its start.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      core_wdata <= '0;
      core_key   <= '0;
      core_delta <= '0;
      core_round <= '0;
      sh_mode    <= 1'b0;
      enc_write  <= 1'b0;
      dec_write  <= 1'b0;
      timer      <= '0;
      vld_q      <= 1'b0;
    end else begin
      enc_write <= 1'b0;
      dec_write <= 1'b0;
      vld_q     <= vld_sel;
      if (issue) begin
        core_wdata <= tx_mem[tx_rp];
        core_key   <= key;
        core_delta <= cfg_delta;
        core_round <= cfg_round;
        sh_mode    <= ctrl_mode;
        enc_write  <= ~ctrl_mode;
        dec_write  <= ctrl_mode;
        timer      <= '0;
      end else if (state_q == S_WAIT) begin
        timer <= timer + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tx_mem[i] <= '0;
        rx_mem[i] <= '0;
      end
      tx_wp  <= '0;
      tx_rp  <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else if (clr) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= apb.pwdata;
        tx_wp         <= tx_wp + AW'(1);
      end
      if (tx_pop) tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);

      if (rx_push) begin
        rx_mem[rx_wp] <= sh_mode ? dec_rdata : enc_rdata;
        rx_wp         <= rx_wp + AW'(1);
      end
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_comb begin
    prdata_c = '0;
    if (rd_acc) begin
      case (ridx)
        R_CTRL:   prdata_c = {28'd0, ctrl_ie, 1'b0, ctrl_mode, ctrl_en};
        R_CFG:    prdata_c = {cfg_delta, 13'd0, cfg_round};
        R_KEYLO:  prdata_c = key[31:0];
        R_KEYHI:  prdata_c = key[63:32];
        R_RXDATA: prdata_c = rx_empty ? 32'd0 : rx_mem[rx_rp];
        R_STATUS: prdata_c = {16'd0, rx_cnt4, tx_cnt4, 2'd0, err, busy,
                              rx_empty, rx_full, tx_empty, tx_full};
        default:  prdata_c = '0;
      endcase
    end
  end

  assign apb.prdata  = prdata_c;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = (wr_acc & (ridx == R_TXDATA) & tx_full) |
                       (rd_acc & (ridx == R_RXDATA) & rx_empty) |
                       (apb.psel & apb.penable & (ridx == R_NONE));
endmodule
